// File: rtl/rvc_fetch_align.sv
// Instruction aligner: splits word-aligned fetch words into 16/32-bit instructions,
// stitches instructions that straddle words, and restarts cleanly on redirect.
module rvc_fetch_align #(
    parameter int unsigned           XLEN     = 32,
    parameter logic [XLEN-1:0]       RESET_PC = 32'h8000_0000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic [XLEN-1:0] in_addr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic            out_compressed,
    output logic [XLEN-1:0] out_pc
);

    logic [15:0]     q [4];
    logic [15:0]     nq [4];
    logic [2:0]      count;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] exp_addr;
    logic            skip_lo;

    logic            head_wide;
    logic            sel_valid;
    logic            pop;
    logic [2:0]      pop_n;
    logic            match;
    logic [2:0]      push_n;
    logic [2:0]      base;
    logic [15:0]     first_half;

    assign head_wide = (q[0][1:0] == 2'b11);
    assign in_ready  = (count <= 3'd2) | redirect_valid;
    assign out_pc    = pc;

    always_comb begin
        sel_valid      = 1'b0;
        out_compressed = 1'b0;
        out_inst       = '0;
        if (count >= 3'd1 && !head_wide) begin
            sel_valid      = 1'b1;
            out_compressed = 1'b1;
            out_inst       = {16'h0000, q[0]};
        end else if (count >= 3'd2 && head_wide) begin
            sel_valid = 1'b1;
            out_inst  = {q[1], q[0]};
        end
    end

    assign out_valid = sel_valid & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign pop_n     = pop ? (out_compressed ? 3'd1 : 3'd2) : 3'd0;

    assign match      = in_valid & in_ready & ~redirect_valid & (in_addr == exp_addr);
    assign push_n     = match ? (skip_lo ? 3'd1 : 3'd2) : 3'd0;
    assign first_half = skip_lo ? in_data[31:16] : in_data[15:0];
    assign base       = count - pop_n;

    // Shift out popped halfwords first, then append new ones behind the survivors.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            logic [2:0] src;
            src   = 3'(i) + pop_n;
            nq[i] = (src < 3'd4) ? q[src[1:0]] : '0;
            if (push_n != 3'd0 && 3'(i) == base)
                nq[i] = first_half;
            if (push_n == 3'd2 && 3'(i) == base + 3'd1)
                nq[i] = in_data[31:16];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) q[i] <= '0;
            count    <= '0;
            pc       <= RESET_PC;
            exp_addr <= {RESET_PC[XLEN-1:2], 2'b00};
            skip_lo  <= RESET_PC[1];
        end else if (redirect_valid) begin
            count    <= '0;
            pc       <= {redirect_pc[XLEN-1:1], 1'b0};
            exp_addr <= {redirect_pc[XLEN-1:2], 2'b00};
            skip_lo  <= redirect_pc[1];
        end else begin
            for (int unsigned i = 0; i < 4; i++) q[i] <= nq[i];
            count <= count - pop_n + push_n;
            if (pop)
                pc <= pc + XLEN'({pop_n, 1'b0});
            if (match) begin
                exp_addr <= exp_addr + XLEN'(4);
                skip_lo  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rvc_fetch_align.sv
// Scoreboard bench for rvc_fetch_align: directed fetch words, expected instructions
// queued at issue time and checked by an independent output monitor.
module tb_rvc_fetch_align;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [31:0] in_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_compressed;
    logic [31:0] out_pc;

    typedef struct packed {
        logic [31:0] inst;
        logic        c;
        logic [31:0] pc;
    } exp_t;

    exp_t sbq[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    rvc_fetch_align #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_compressed(out_compressed), .out_pc(out_pc)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Monitor: every accepted output must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("unexpected_output_pc", out_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out_inst", out_inst, e.inst);
                check("out_compressed", {31'b0, out_compressed}, {31'b0, e.c});
                check("out_pc", out_pc, e.pc);
            end
        end
    end

    task automatic expect_out(input logic [31:0] inst, input logic c, input logic [31:0] pc);
        exp_t e;
        e.inst = inst; e.c = c; e.pc = pc;
        sbq.push_back(e);
    endtask

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send_word(input logic [31:0] addr, input logic [31:0] data, output int waits);
        in_valid = 1'b1; in_addr = addr; in_data = data;
        waits = 0;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("drain_remaining", sbq.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sbq.delete();
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1; redirect_pc = target;
        @(posedge clock); #1;
        redirect_valid = 1'b0;
    endtask

    int w;
    int seen;

    initial begin
        // Reset state
        do_reset();
        @(negedge clock);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_compressed", {31'b0, out_compressed}, 32'd0);
        check("rst_out_pc", out_pc, RST_PC);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock); #1;

        // Two compressed parcels in one word
        expect_out(32'h0000_4501, 1'b1, 32'h8000_0000);
        expect_out(32'h0000_0041, 1'b1, 32'h8000_0002);
        send_word(32'h8000_0000, 32'h0041_4501, w);
        wait_drain();

        // Two aligned 32-bit instructions
        do_reset();
        expect_out(32'h0000_0513, 1'b0, 32'h8000_0000);
        expect_out(32'h0000_0093, 1'b0, 32'h8000_0004);
        send_word(32'h8000_0000, 32'h0000_0513, w);
        send_word(32'h8000_0004, 32'h0000_0093, w);
        wait_drain();

        // Straddling 32-bit instruction waits for the next word
        do_reset();
        expect_out(32'h0000_4501, 1'b1, 32'h8000_0000);
        send_word(32'h8000_0000, 32'h0513_4501, w);
        @(posedge clock); @(negedge clock);
        check("straddle_wait_valid", {31'b0, out_valid}, 32'd0);
        check("straddle_wait_pc", out_pc, 32'h8000_0002);
        @(posedge clock); #1;
        expect_out(32'h0000_0513, 1'b0, 32'h8000_0002);
        expect_out(32'h0000_1234, 1'b1, 32'h8000_0006);
        send_word(32'h8000_0004, 32'h1234_0000, w);
        wait_drain();

        // Halfword-aligned redirect drops the low half
        do_redirect(32'h8000_0102);
        check("redir_pc", out_pc, 32'h8000_0102);
        expect_out(32'h0000_4505, 1'b1, 32'h8000_0102);
        send_word(32'h8000_0100, 32'h4505_ABCD, w);
        wait_drain();

        // Stale word after redirect is consumed silently
        do_redirect(32'h8000_0200);
        send_word(32'h8000_0008, 32'h4581_4501, w);
        check("stale_accept_waits", w, 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("stale_no_output", seen, 32'd0);
        @(posedge clock); #1;
        expect_out(32'h0000_4501, 1'b1, 32'h8000_0200);
        expect_out(32'h0000_4581, 1'b1, 32'h8000_0202);
        send_word(32'h8000_0200, 32'h4581_4501, w);
        wait_drain();

        // Backpressure: queue fills to 4, input stalls, then drains in order
        out_ready = 1'b0;
        expect_out(32'h0000_4605, 1'b1, 32'h8000_0204);
        expect_out(32'h0000_4609, 1'b1, 32'h8000_0206);
        expect_out(32'h0000_460D, 1'b1, 32'h8000_0208);
        expect_out(32'h0000_4611, 1'b1, 32'h8000_020A);
        expect_out(32'h0000_4615, 1'b1, 32'h8000_020C);
        expect_out(32'h0000_4619, 1'b1, 32'h8000_020E);
        send_word(32'h8000_0204, 32'h4609_4605, w);
        send_word(32'h8000_0208, 32'h4611_460D, w);
        @(negedge clock);
        check("full_in_ready", {31'b0, in_ready}, 32'd0);
        check("full_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clock); #1;
        fork
            send_word(32'h8000_020C, 32'h4619_4615, w);
            begin
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        check("stall_observed", {31'b0, (w > 0)}, 32'd1);
        wait_drain();

        // Reset mid-stream discards queued halfwords
        out_ready = 1'b0;
        send_word(32'h8000_0210, 32'h4621_461D, w);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_out_pc", out_pc, RST_PC);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clock); #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
